// File: rtl/stopwatch_btn_ctrl.sv
// Push-button front end for the stopwatch: synchronise, debounce and edge-detect two buttons into a run level and a clear pulse.
// Optional feature macro: LONG_PRESS_CLEAR_EN (holding start/stop long enough also issues a clear).

module stopwatch_btn_chan #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic db,
  output logic rise
);

  logic             s1;
  logic             s2;
  logic             db_q;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      db   <= 1'b0;
      db_q <= 1'b0;
      cnt  <= '0;
    end else begin
      s1   <= btn;
      s2   <= s1;
      db_q <= db;
      // Any return to the accepted level restarts the stability window.
      if (s2 == db) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        db  <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign rise = db & ~db_q;

endmodule

module stopwatch_btn_ctrl #(
  parameter int DEBOUNCE_CYCLES   = 1_000_000,
  parameter int CNT_W             = 20,
  parameter int LONG_PRESS_CYCLES = 200_000_000,
  parameter int LP_W              = 28
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_ss,
  input  logic btn_clr,
  output logic start,
  output logic clear,
  output logic ss_db,
  output logic clr_db
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state;
  state_t state_next;
  logic   ss_rise;
  logic   clr_rise;
  logic   lp_hit;

  if (DEBOUNCE_CYCLES < 2 || (64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_bad_db
    $error("stopwatch_btn_ctrl: DEBOUNCE_CYCLES must be >=2 and fit in CNT_W");
  end
  if (LONG_PRESS_CYCLES < 2 || (64'd1 << LP_W) <= 64'(LONG_PRESS_CYCLES)) begin : g_bad_lp
    $error("stopwatch_btn_ctrl: LONG_PRESS_CYCLES must be >=2 and fit in LP_W");
  end

  stopwatch_btn_chan #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_ss (
    .clk   (clk),
    .rst_n (reset),
    .btn   (btn_ss),
    .db    (ss_db),
    .rise  (ss_rise)
  );

  stopwatch_btn_chan #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_clr (
    .clk   (clk),
    .rst_n (reset),
    .btn   (btn_clr),
    .db    (clr_db),
    .rise  (clr_rise)
  );

`ifdef LONG_PRESS_CLEAR_EN
  logic [LP_W-1:0] lp;

  // Counter parks one past the trigger value so a held button fires only once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lp <= '0;
    end else if (!ss_db) begin
      lp <= '0;
    end else if (lp != LP_W'(LONG_PRESS_CYCLES)) begin
      lp <= lp + 1'b1;
    end
  end

  assign lp_hit = ss_db && (lp == LP_W'(LONG_PRESS_CYCLES - 1));
`else
  assign lp_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      clear <= 1'b0;
    end else begin
      state <= state_next;
      clear <= clr_rise | lp_hit;
    end
  end

  // Clear has priority over a simultaneous start/stop toggle.
  always_comb begin
    state_next = state;
    if (clr_rise || lp_hit) begin
      state_next = IDLE;
    end else if (ss_rise) begin
      state_next = (state == RUN) ? IDLE : RUN;
    end
  end

  assign start = (state == RUN);

endmodule
